// File: rtl/reorder_buffer_if.sv
// Bus bundle between the reorder buffer and its neighbours in the O3 pipeline:
// dispatch (allocation), the CDB (completion), and commit_stage (retirement).
// The master modport is the pipeline side; the slave modport is the ROB itself.
`ifndef XLEN
`define XLEN 32
`endif

interface reorder_buffer_if #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int DATA_W    = `XLEN
);
    logic              dispatch_valid;
    logic [4:0]        dispatch_dest_reg;
    logic              dispatch_wr_mem;
    logic [DATA_W-1:0] dispatch_pc;
    logic              dispatch_ready;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              head_valid;
    logic              head_ready;
    logic [4:0]        head_dest_reg;
    logic              head_wr_mem;
    logic [DATA_W-1:0] head_value;
    logic [DATA_W-1:0] head_pc;
    logic              commit_ack;
    logic              flush;
    logic [TAG_W:0]    count;

    modport master (
        output dispatch_valid, dispatch_dest_reg, dispatch_wr_mem, dispatch_pc,
        input  dispatch_ready, dispatch_tag,
        output cdb_valid, cdb_tag, cdb_value,
        input  head_valid, head_ready, head_dest_reg, head_wr_mem, head_value, head_pc,
        output commit_ack, flush,
        input  count
    );

    modport slave (
        input  dispatch_valid, dispatch_dest_reg, dispatch_wr_mem, dispatch_pc,
        output dispatch_ready, dispatch_tag,
        input  cdb_valid, cdb_tag, cdb_value,
        output head_valid, head_ready, head_dest_reg, head_wr_mem, head_value, head_pc,
        input  commit_ack, flush,
        output count
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: dispatch allocates at the tail in program order,
// the CDB marks entries complete, and the oldest entry is exposed on head_*
// for commit_stage to retire with commit_ack.
// Optional build macro ROB_CDB_FORWARD_EN: a CDB broadcast that targets the
// valid head entry makes it committable in the same cycle, with the broadcast
// value forwarded onto head_value.
`ifndef XLEN
`define XLEN 32
`endif

module reorder_buffer #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int DATA_W    = `XLEN
) (
    input logic          clock,
    input logic          reset,
    reorder_buffer_if.slave rob
);
    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_complete;
    logic [4:0]           r_destReg [ROB_DEPTH];
    logic                 r_wrMem   [ROB_DEPTH];
    logic [DATA_W-1:0]    r_value   [ROB_DEPTH];
    logic [DATA_W-1:0]    r_pc      [ROB_DEPTH];
    logic [TAG_W:0]       r_headPtr;
    logic [TAG_W:0]       r_tailPtr;

    logic [TAG_W-1:0]     w_headIdx;
    logic [TAG_W-1:0]     w_tailIdx;
    logic                 w_full;
    logic                 w_dispatchFire;
    logic                 w_cdbHit;
    logic                 w_commitFire;
    logic                 w_headReady;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    // Readiness looks only at registered pointers, so a same-cycle commit
    // never opens a slot for a dispatch while full.
    always_comb begin
        w_headIdx      = r_headPtr[TAG_W-1:0];
        w_tailIdx      = r_tailPtr[TAG_W-1:0];
        w_full         = (w_headIdx == w_tailIdx) && (r_headPtr[TAG_W] != r_tailPtr[TAG_W]);
        w_dispatchFire = rob.dispatch_valid && !w_full;
        w_cdbHit       = rob.cdb_valid && r_valid[rob.cdb_tag];
        w_commitFire   = rob.commit_ack && w_headReady;
    end

    // Head view is read straight out of the head slot; an invalid slot reads as
    // all zeros, which also covers the empty buffer.
    always_comb begin
        rob.head_valid    = 1'b0;
        w_headReady       = 1'b0;
        rob.head_dest_reg = '0;
        rob.head_wr_mem   = 1'b0;
        rob.head_value    = '0;
        rob.head_pc       = '0;
        if (r_valid[w_headIdx]) begin
            rob.head_valid    = 1'b1;
            w_headReady       = r_complete[w_headIdx];
            rob.head_dest_reg = r_destReg[w_headIdx];
            rob.head_wr_mem   = r_wrMem[w_headIdx];
            rob.head_value    = r_value[w_headIdx];
            rob.head_pc       = r_pc[w_headIdx];
`ifdef ROB_CDB_FORWARD_EN
            if (rob.cdb_valid && (rob.cdb_tag == w_headIdx)) begin
                w_headReady    = 1'b1;
                rob.head_value = rob.cdb_value;
            end
`endif
        end
        rob.head_ready = w_headReady;
    end

    // Bookkeeping outputs derived from the registered pointers.
    always_comb begin
        rob.dispatch_ready = !w_full;
        rob.dispatch_tag   = w_tailIdx;
        rob.count          = r_tailPtr - r_headPtr;
    end

    // Occupancy state and pointers. Flush outranks everything else; the
    // dispatched slot is always invalid beforehand, so a CDB hit can never land
    // on it, and a commit clears its slot after any CDB write to the same slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_headPtr  <= '0;
            r_tailPtr  <= '0;
        end else if (rob.flush) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_headPtr  <= '0;
            r_tailPtr  <= '0;
        end else begin
            if (w_cdbHit) begin
                r_complete[rob.cdb_tag] <= 1'b1;
            end
            if (w_dispatchFire) begin
                r_valid[w_tailIdx]    <= 1'b1;
                r_complete[w_tailIdx] <= 1'b0;
                r_tailPtr             <= r_tailPtr + PTR_ONE;
            end
            if (w_commitFire) begin
                r_valid[w_headIdx]    <= 1'b0;
                r_complete[w_headIdx] <= 1'b0;
                r_headPtr             <= r_headPtr + PTR_ONE;
            end
        end
    end

    // Payload storage needs no reset: nothing is visible unless its valid bit is set.
    always_ff @(posedge clock) begin
        if (!rob.flush) begin
            if (w_dispatchFire) begin
                r_destReg[w_tailIdx] <= rob.dispatch_dest_reg;
                r_wrMem[w_tailIdx]   <= rob.dispatch_wr_mem;
                r_pc[w_tailIdx]      <= rob.dispatch_pc;
                r_value[w_tailIdx]   <= '0;
            end
            if (w_cdbHit) begin
                r_value[rob.cdb_tag] <= rob.cdb_value;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (default build, CDB forwarding disabled).
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_reorder_buffer;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    reorder_buffer_if #(.ROB_DEPTH(8), .DATA_W(32)) rob_bus ();

    reorder_buffer #(.ROB_DEPTH(8), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .rob   (rob_bus)
    );

    // Free-running 10ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rob_bus.dispatch_valid    = 1'b0;
        rob_bus.dispatch_dest_reg = 5'd0;
        rob_bus.dispatch_wr_mem   = 1'b0;
        rob_bus.dispatch_pc       = 32'h0;
        rob_bus.cdb_valid         = 1'b0;
        rob_bus.cdb_tag           = 3'd0;
        rob_bus.cdb_value         = 32'h0;
        rob_bus.commit_ack        = 1'b0;
        rob_bus.flush             = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic dispatch(input logic [4:0] dest, input logic wrMem, input logic [31:0] pc);
        rob_bus.dispatch_valid    = 1'b1;
        rob_bus.dispatch_dest_reg = dest;
        rob_bus.dispatch_wr_mem   = wrMem;
        rob_bus.dispatch_pc       = pc;
        tick();
        idle();
    endtask

    task automatic complete(input logic [2:0] tag, input logic [31:0] value);
        rob_bus.cdb_valid = 1'b1;
        rob_bus.cdb_tag   = tag;
        rob_bus.cdb_value = value;
        tick();
        rob_bus.cdb_valid = 1'b0;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        idle();
        do_reset();
        vectors++;
        if (rob_bus.dispatch_ready !== 1'b1) begin
            $display("[TB] FAIL reset_dispatch_ready got %b want 1", rob_bus.dispatch_ready); miscompares++;
        end
        vectors++;
        if (rob_bus.dispatch_tag !== 3'd0) begin
            $display("[TB] FAIL reset_dispatch_tag got %0d want 0", rob_bus.dispatch_tag); miscompares++;
        end
        vectors++;
        if ({rob_bus.head_valid, rob_bus.head_ready, rob_bus.head_wr_mem} !== 3'b000) begin
            $display("[TB] FAIL reset_head_flags got %b%b%b want 000", rob_bus.head_valid,
                     rob_bus.head_ready, rob_bus.head_wr_mem); miscompares++;
        end
        vectors++;
        if ({rob_bus.head_dest_reg, rob_bus.head_value, rob_bus.head_pc} !== 69'd0) begin
            $display("[TB] FAIL reset_head_fields got %h/%h/%h want 0", rob_bus.head_dest_reg,
                     rob_bus.head_value, rob_bus.head_pc); miscompares++;
        end
        vectors++;
        if (rob_bus.count !== 4'd0) begin
            $display("[TB] FAIL reset_count got %0d want 0", rob_bus.count); miscompares++;
        end
    endtask

    // One store dispatched, completed via the CDB, then retired.
    task automatic test_single();
        dispatch(5'b00001, 1'b1, 32'h100);
        vectors++;
        if ({rob_bus.head_valid, rob_bus.head_ready, rob_bus.head_wr_mem} !== 3'b101) begin
            $display("[TB] FAIL single_head_flags got %b%b%b want 101", rob_bus.head_valid,
                     rob_bus.head_ready, rob_bus.head_wr_mem); miscompares++;
        end
        vectors++;
        if (rob_bus.head_dest_reg !== 5'd1 || rob_bus.head_pc !== 32'h100 || rob_bus.head_value !== 32'h0) begin
            $display("[TB] FAIL single_head_fields got %0d/%h/%h want 1/100/0", rob_bus.head_dest_reg,
                     rob_bus.head_pc, rob_bus.head_value); miscompares++;
        end
        vectors++;
        if (rob_bus.count !== 4'd1 || rob_bus.dispatch_tag !== 3'd1) begin
            $display("[TB] FAIL single_count_tag got %0d/%0d want 1/1", rob_bus.count,
                     rob_bus.dispatch_tag); miscompares++;
        end
        complete(3'd0, 32'hDEAD);
        vectors++;
        if (rob_bus.head_ready !== 1'b1 || rob_bus.head_value !== 32'hDEAD) begin
            $display("[TB] FAIL cdb_complete got %b/%h want 1/0000dead", rob_bus.head_ready,
                     rob_bus.head_value); miscompares++;
        end
        rob_bus.commit_ack = 1'b1;
        tick();
        rob_bus.commit_ack = 1'b0;
        vectors++;
        if (rob_bus.head_valid !== 1'b0 || rob_bus.count !== 4'd0 || rob_bus.head_ready !== 1'b0) begin
            $display("[TB] FAIL commit_single got valid=%b count=%0d ready=%b want 0/0/0",
                     rob_bus.head_valid, rob_bus.count, rob_bus.head_ready); miscompares++;
        end
    endtask

    // Fill all eight slots; a ninth dispatch alongside a commit must stall.
    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            dispatch(5'(i), 1'b0, 32'(i * 4));
        end
        vectors++;
        if (rob_bus.dispatch_ready !== 1'b0 || rob_bus.count !== 4'd8 || rob_bus.dispatch_tag !== 3'd0) begin
            $display("[TB] FAIL full_state got ready=%b count=%0d tag=%0d want 0/8/0",
                     rob_bus.dispatch_ready, rob_bus.count, rob_bus.dispatch_tag); miscompares++;
        end
        complete(3'd0, 32'h55);
        rob_bus.dispatch_valid = 1'b1;
        rob_bus.dispatch_pc    = 32'hBAD;
        rob_bus.commit_ack     = 1'b1;
        tick();
        idle();
        vectors++;
        if (rob_bus.count !== 4'd7 || rob_bus.dispatch_tag !== 3'd0 || rob_bus.dispatch_ready !== 1'b1) begin
            $display("[TB] FAIL full_stall got count=%0d tag=%0d ready=%b want 7/0/1",
                     rob_bus.count, rob_bus.dispatch_tag, rob_bus.dispatch_ready); miscompares++;
        end
        vectors++;
        if (rob_bus.head_pc !== 32'h4 || rob_bus.head_dest_reg !== 5'd1 || rob_bus.head_ready !== 1'b0) begin
            $display("[TB] FAIL full_new_head got pc=%h dest=%0d ready=%b want 4/1/0",
                     rob_bus.head_pc, rob_bus.head_dest_reg, rob_bus.head_ready); miscompares++;
        end
    endtask

    // Younger entries complete first; retirement still follows program order.
    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dispatch(5'(i + 10), 1'b0, 32'h200 + 32'(i * 4));
        end
        complete(3'd2, 32'h22);
        complete(3'd1, 32'h11);
        rob_bus.commit_ack = 1'b1;
        tick();
        vectors++;
        if (rob_bus.head_valid !== 1'b1 || rob_bus.head_ready !== 1'b0 || rob_bus.count !== 4'd3) begin
            $display("[TB] FAIL ooo_blocked got valid=%b ready=%b count=%0d want 1/0/3",
                     rob_bus.head_valid, rob_bus.head_ready, rob_bus.count); miscompares++;
        end
        complete(3'd0, 32'h0A);
        vectors++;
        if (rob_bus.head_value !== 32'h0A || rob_bus.count !== 4'd3 || rob_bus.head_pc !== 32'h200) begin
            $display("[TB] FAIL ooo_head0 got value=%h count=%0d pc=%h want 0a/3/200",
                     rob_bus.head_value, rob_bus.count, rob_bus.head_pc); miscompares++;
        end
        tick();
        vectors++;
        if (rob_bus.head_value !== 32'h11 || rob_bus.head_pc !== 32'h204 || rob_bus.count !== 4'd2) begin
            $display("[TB] FAIL ooo_retire0 got value=%h pc=%h count=%0d want 11/204/2",
                     rob_bus.head_value, rob_bus.head_pc, rob_bus.count); miscompares++;
        end
        tick();
        vectors++;
        if (rob_bus.head_value !== 32'h22 || rob_bus.head_dest_reg !== 5'd12 || rob_bus.count !== 4'd1) begin
            $display("[TB] FAIL ooo_retire1 got value=%h dest=%0d count=%0d want 22/12/1",
                     rob_bus.head_value, rob_bus.head_dest_reg, rob_bus.count); miscompares++;
        end
        tick();
        rob_bus.commit_ack = 1'b0;
        vectors++;
        if (rob_bus.head_valid !== 1'b0 || rob_bus.count !== 4'd0 || rob_bus.dispatch_tag !== 3'd3) begin
            $display("[TB] FAIL ooo_retire2 got valid=%b count=%0d tag=%0d want 0/0/3",
                     rob_bus.head_valid, rob_bus.count, rob_bus.dispatch_tag); miscompares++;
        end
    endtask

    // Flush beats a same-cycle dispatch and CDB broadcast.
    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dispatch(5'(i), 1'b1, 32'h300 + 32'(i));
        end
        rob_bus.flush          = 1'b1;
        rob_bus.dispatch_valid = 1'b1;
        rob_bus.cdb_valid      = 1'b1;
        rob_bus.cdb_tag        = 3'd0;
        rob_bus.cdb_value      = 32'h77;
        tick();
        idle();
        vectors++;
        if (rob_bus.count !== 4'd0 || rob_bus.head_valid !== 1'b0 || rob_bus.dispatch_tag !== 3'd0) begin
            $display("[TB] FAIL flush_state got count=%0d valid=%b tag=%0d want 0/0/0",
                     rob_bus.count, rob_bus.head_valid, rob_bus.dispatch_tag); miscompares++;
        end
        dispatch(5'd9, 1'b0, 32'h400);
        vectors++;
        if (rob_bus.head_ready !== 1'b0 || rob_bus.head_pc !== 32'h400 || rob_bus.head_value !== 32'h0) begin
            $display("[TB] FAIL flush_realloc got ready=%b pc=%h value=%h want 0/400/0",
                     rob_bus.head_ready, rob_bus.head_pc, rob_bus.head_value); miscompares++;
        end
    endtask

    // Reset raised between edges clears the outputs without waiting for a clock.
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dispatch(5'(i), 1'b0, 32'h500 + 32'(i));
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (rob_bus.count !== 4'd0 || rob_bus.head_valid !== 1'b0 || rob_bus.dispatch_tag !== 3'd0) begin
            $display("[TB] FAIL async_reset got count=%0d valid=%b tag=%0d want 0/0/0",
                     rob_bus.count, rob_bus.head_valid, rob_bus.dispatch_tag); miscompares++;
        end
        vectors++;
        if (rob_bus.head_pc !== 32'h0 || rob_bus.dispatch_ready !== 1'b1) begin
            $display("[TB] FAIL async_reset_fields got pc=%h ready=%b want 0/1",
                     rob_bus.head_pc, rob_bus.dispatch_ready); miscompares++;
        end
        tick();
        reset = 1'b0;
    endtask

    // Scenarios run back to back from a single process.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle();
        test_reset();
        test_single();
        test_full();
        test_out_of_order();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer that is the producer of the head entry consumed by commit_stage.
- Dispatch allocates entries in program order.
- Execute/CDB marks entries complete.
- The oldest entry is presented on head_* ports; commit_stage retires it with commit_ack.
- Sits between dispatch, the CDB and commit in the O3 pipeline.

Parameters:
ROB_DEPTH, 8, number of entries; power of two, >= 2
TAG_W, $clog2(ROB_DEPTH), entry index width
DATA_W, `XLEN, result/PC width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
dispatch_valid  in  1  allocation request
dispatch_dest_reg  in  5  architectural destination
dispatch_wr_mem  in  1  entry is a store
dispatch_pc  in  DATA_W  instruction PC
dispatch_ready  out  1  entry available
dispatch_tag  out  TAG_W  index the next allocation will receive (tail)
cdb_valid  in  1  completion broadcast
cdb_tag  in  TAG_W  completing entry index
cdb_value  in  DATA_W  result
head_valid  out  1  head entry occupied
head_ready  out  1  head entry complete, committable
head_dest_reg  out  5  head destination
head_wr_mem  out  1  head is a store
head_value  out  DATA_W  head result
head_pc  out  DATA_W  head PC
commit_ack  in  1  commit_stage retires head this cycle
flush  in  1  squash all entries
count  out  TAG_W+1  occupied entries

Behaviour:
- Storage:
  - Per entry: valid, complete, dest_reg, wr_mem, value, pc.
  - head_ptr and tail_ptr are TAG_W+1 bits; the MSB is a wrap bit.
  - empty = pointers equal; full = indices equal and wrap bits differ.
- Reset (async):
  - All valid/complete bits 0; head_ptr = tail_ptr = 0; count = 0.
  - Outputs: dispatch_ready = 1, dispatch_tag = 0, head_valid = 0, head_ready = 0; head_dest_reg, head_wr_mem, head_value, head_pc = 0.
  - Reset mid-operation discards everything with no retirement.
- Dispatch:
  - Accepted at a rising edge when dispatch_valid && dispatch_ready.
  - Writes the tail entry: valid = 1, complete = 0, value = 0. Tail increments modulo 2*ROB_DEPTH.
  - dispatch_ready = !full and depends only on registered state; when full, dispatch stalls even if commit_ack is high the same cycle.
  - dispatch_valid while not ready is ignored. dispatch_tag always shows the tail index.
- Completion:
  - cdb_valid at an edge with a valid target entry sets complete = 1 and value = cdb_value.
  - Completion to an invalid entry is ignored; duplicate completion overwrites value.
  - Completion is visible on head_ready/head_value from the next cycle (1-cycle latency).
- Head outputs:
  - Combinational from entry[head_ptr index].
  - head_valid = entry valid; head_ready = valid && complete.
  - When empty, all head_* fields read 0.
- Commit:
  - At an edge with commit_ack && head_ready: clear the head entry valid/complete; head increments.
  - commit_ack without head_ready is ignored.
  - At most one retirement per cycle.
- Simultaneous events:
  - Dispatch and commit in the same cycle: count unchanged, both pointers advance.
  - CDB and commit cannot target the same entry; the head must already be complete to commit.
  - CDB to the entry being dispatched the same cycle is ignored (entry was invalid).
- Flush:
  - Synchronous; highest priority over dispatch, CDB and commit that cycle.
  - Clears all valid bits; head_ptr = tail_ptr = 0; count = 0.
- count: tail_ptr − head_ptr (TAG_W+1 bits), updated each edge.

Optional Feature:
ROB_CDB_FORWARD_EN:
- Defined: when cdb_valid && cdb_tag == head index && head entry valid, head_ready = 1 and head_value = cdb_value combinationally in the same cycle. commit_ack that cycle retires the head with the forwarded value.
- Undefined: head_ready rises one cycle after the CDB write, as above.

Test Plan:
- Reset, then 1 dispatch (dest 5'b00001, wr_mem 1, pc 32'h100): next cycle head_valid = 1, head_ready = 0, head_wr_mem = 1, count = 1, dispatch_tag = 1.
- CDB tag 0, value 32'hDEAD: next cycle head_ready = 1, head_value = 32'hDEAD. commit_ack: next cycle head_valid = 0, count = 0.
- 8 dispatches: dispatch_ready = 0, count = 8. A ninth dispatch with commit_ack the same cycle is rejected; count = 7 after, tail index = 0 (wrap).
- Complete entries 2 and 1 before 0; commit_ack held: retire order 0, 1, 2 on consecutive cycles only after entry 0 completes.
- 4 entries, flush asserted with dispatch_valid and cdb_valid the same cycle: next cycle count = 0, head_valid = 0, dispatch_tag = 0.
- Assert reset asynchronously mid-clock with 3 entries: outputs clear immediately, before the next edge.
